// File: rtl/otter_muldiv_pkg.sv
// Shared types and constants for the OTTER iterative multiply/divide unit.
package otter_muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      FINISH
   } muldiv_state_t;

   localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
   localparam logic [31:0] INT_MIN  = 32'h8000_0000;

endpackage

// File: rtl/otter_muldiv.sv
// Iterative RV32M multiply/divide: 32-cycle shift-add multiply and
// restoring divide sharing one counter and one set of operand registers.
module otter_muldiv
   import otter_muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [2:0]       FUNCT3,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] RESULT
);

   muldiv_state_t      state;
   muldiv_op_t         op;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH-1:0]   quot;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   spec_res;
   logic [2*WIDTH-1:0] prod;
   logic               neg_a;
   logic               neg_b;
   logic               special;

   muldiv_op_t       start_op;
   logic             sgn_a_in;
   logic             sgn_b_in;
   logic             na_in;
   logic             nb_in;
   logic [WIDTH-1:0] a_mag_in;
   logic [WIDTH-1:0] b_mag_in;
   logic             div_zero;
   logic             div_ovf;
   logic [WIDTH-1:0] spec_in;

   assign start_op = muldiv_op_t'(FUNCT3);
   assign sgn_a_in = start_op inside {OP_MUL, OP_MULH, OP_MULHSU,
                                      OP_DIV, OP_REM};
   assign sgn_b_in = start_op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
   assign na_in    = sgn_a_in & A[WIDTH-1];
   assign nb_in    = sgn_b_in & B[WIDTH-1];
   assign a_mag_in = na_in ? (~A + 1'b1) : A;
   assign b_mag_in = nb_in ? (~B + 1'b1) : B;

   // Division corner cases bypass the iteration entirely.
   assign div_zero = FUNCT3[2] && (B == '0);
   assign div_ovf  = FUNCT3[2] && !FUNCT3[0]
                     && (A == INT_MIN) && (B == ALL_ONES);
   assign spec_in  = div_zero ? (FUNCT3[1] ? A : ALL_ONES)
                              : (FUNCT3[1] ? '0 : INT_MIN);

   logic [WIDTH:0] mul_sum;
   logic [WIDTH:0] div_shift;
   logic [WIDTH:0] div_diff;
   logic           q_bit;

   assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]}
                      + {1'b0, (prod[0] ? a_mag : '0)};
   assign div_shift = {rem, quot[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, b_mag};
   assign q_bit     = ~div_diff[WIDTH];

   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix;
   logic [WIDTH-1:0]   rem_fix;

   assign prod_fix = (neg_a ^ neg_b) ? (~prod + 1'b1) : prod;
   assign quot_fix = (neg_a ^ neg_b) ? (~quot + 1'b1) : quot;
   assign rem_fix  = neg_a ? (~rem + 1'b1) : rem;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         op       <= OP_MUL;
         cnt      <= '0;
         a_mag    <= '0;
         b_mag    <= '0;
         quot     <= '0;
         rem      <= '0;
         spec_res <= '0;
         prod     <= '0;
         neg_a    <= 1'b0;
         neg_b    <= 1'b0;
         special  <= 1'b0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
         RESULT   <= '0;
      end else begin
         DONE <= (state == FINISH);
         BUSY <= (state == IDLE) ? START : 1'b1;
         unique case (state)
            IDLE: begin
               if (START) begin
                  op       <= start_op;
                  neg_a    <= na_in;
                  neg_b    <= nb_in;
                  a_mag    <= a_mag_in;
                  b_mag    <= b_mag_in;
                  cnt      <= '0;
                  prod     <= {{WIDTH{1'b0}}, b_mag_in};
                  quot     <= a_mag_in;
                  rem      <= '0;
                  special  <= div_zero | div_ovf;
                  spec_res <= spec_in;
                  state    <= (div_zero | div_ovf) ? FIX : CALC;
               end
            end
            CALC: begin
               cnt <= cnt + 1'b1;
               if (op[2]) begin
                  rem  <= q_bit ? div_diff[WIDTH-1:0]
                                : div_shift[WIDTH-1:0];
                  quot <= {quot[WIDTH-2:0], q_bit};
               end else begin
                  prod <= {mul_sum, prod[WIDTH-1:1]};
               end
               if (cnt == {CNT_W{1'b1}})
                  state <= FIX;
            end
            FIX: begin
               if (special) begin
                  RESULT <= spec_res;
               end else begin
                  unique case (op)
                     OP_MUL:    RESULT <= prod_fix[WIDTH-1:0];
                     OP_MULH,
                     OP_MULHSU,
                     OP_MULHU:  RESULT <= prod_fix[2*WIDTH-1:WIDTH];
                     OP_DIV,
                     OP_DIVU:   RESULT <= quot_fix;
                     OP_REM,
                     OP_REMU:   RESULT <= rem_fix;
                  endcase
               end
               state <= FINISH;
            end
            FINISH: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/otter_muldiv.md
Name: otter_muldiv

Overview:
- Iterative RV32M multiply/divide unit for the OTTER execute stage.
- Directly consumes the register file read ports: A is driven from RS1 and B from RS2.
- Accepts one operation per START pulse, stalls the pipeline via BUSY, and returns a 32-bit result with a one-cycle DONE pulse.
- RESULT feeds the writeback mux into the register file WD input.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is supported.
- CNT_W, 5, iteration counter width (log2 WIDTH).

Ports:
- CLK  input  1  system clock, rising-edge active
- RST  input  1  asynchronous, active-high reset
- START  input  1  begin operation. Sampled only in IDLE.
- FUNCT3  input  3  RV32M op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- A  input  32  operand rs1 (from RS1)
- B  input  32  operand rs2 (from RS2)
- BUSY  output  1  high whenever state != IDLE
- DONE  output  1  single-cycle pulse; RESULT is valid while high
- RESULT  output  32  registered result; holds until the next DONE

Behaviour:
- Interface: one clock CLK; reset RST is asynchronous and active-high.
- Reset (async, any state, including mid-operation):
  - state=IDLE; BUSY=0, DONE=0, RESULT=0.
  - Counter, operand and accumulator registers are cleared.
  - The in-flight operation is discarded; no DONE is produced for it.
- States: IDLE, CALC, FIX, FINISH.
- IDLE:
  - If START=1 at edge n: latch FUNCT3, A, B, sign flags and operand magnitudes; cnt=0.
  - Normal ops go to CALC.
  - Division special cases go straight to FIX (below).
  - START=0: stay in IDLE.
- Sign handling at latch:
  - MUL/MULH/DIV/REM: A and B are signed.
  - MULHSU: A signed, B unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - Signed operands are converted to magnitudes.
- CALC: one iteration per cycle for 32 cycles; cnt increments; cnt==31 at the edge moves to FIX.
  - Multiply: unsigned shift-add into a 64-bit product register.
  - Divide: restoring division, one quotient bit per cycle, 32-bit remainder register.
- FIX: one cycle.
  - Negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ. REM: the remainder takes the dividend's sign.
  - Register RESULT per op: MUL = product[31:0]; MULH/MULHSU/MULHU = product[63:32]; DIV/DIVU = quotient; REM/REMU = remainder.
  - Next state FINISH.
- FINISH: DONE=1 for exactly this cycle; next state IDLE.
- Latency:
  - Normal op: START sampled at edge n; DONE high between edge n+34 and n+35; BUSY high from edge n to edge n+35.
  - Special case: DONE high between edge n+2 and n+3.
  - Back-to-back: a new START is accepted at edge n+35 at the earliest (IDLE cycle).
- Division special cases (per RISC-V spec), detected at START:
  - B==0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give A.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF, DIV/REM): DIV gives 0x80000000; REM gives 0.
- START while BUSY=1 is ignored: no effect on latched operands or timing.
- A, B and FUNCT3 may change freely after the START edge; only the latched copies are used.
- Arithmetic:
  - Negation is two's complement within the stated width.
  - Magnitude of 0x80000000 is 0x80000000 unsigned; no overflow.
- DONE never asserts outside FINISH. RESULT changes only on the FIX edge and on reset.

Decomposition:
- Package otter_muldiv_pkg holds:
  - enum muldiv_op_t for FUNCT3 encodings;
  - enum muldiv_state_t {IDLE, CALC, FIX, FINISH};
  - constants ALL_ONES=32'hFFFFFFFF and INT_MIN=32'h80000000.
- Single module; no sub-module needed. The multiply and divide datapaths share the counter and the operand registers.

Test Plan:
- Reset mid-op: START MUL A=5 B=7, assert RST at cycle 10 -> BUSY=0, DONE=0, RESULT=0 immediately; no DONE afterwards.
- MUL/MULH signed: A=0xFFFFFFFE (-2), B=3 -> MUL RESULT=0xFFFFFFFA and MULH RESULT=0xFFFFFFFF; DONE 34 cycles after START, 1 cycle wide.
- MULHU/MULHSU: A=0xFFFFFFFF, B=0xFFFFFFFF -> MULHU=0xFFFFFFFE; MULHSU=0xFFFFFFFF (-1 x 4294967295, high word).
- Signed divide: DIV A=-7 (0xFFFFFFF9), B=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU A=100 B=7 -> 14; REMU -> 2.
- Special cases:
  - DIV A=42 B=0 -> 0xFFFFFFFF; REM -> 42.
  - DIV A=0x80000000 B=0xFFFFFFFF -> 0x80000000; REM -> 0.
  - All with DONE 2 cycles after START.
- Busy-ignore: START DIVU 100/7, pulse START with MUL 3/3 at cycle 5, change A/B every cycle -> single DONE at cycle 34 with RESULT=14; BUSY drops after; next START accepted.
